// File: rtl/bank_cmd_sequencer_if.sv
// Host-side handshake bundle for bank_cmd_sequencer: command channel in, response channel out.
// master = host driving commands, slave = the sequencer.
interface bank_cmd_sequencer_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 2,
  parameter int QUERY_W = 4
);
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_data;
  logic [QUERY_W-1:0] cmd_query;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_W-1:0]  rsp_data;
  logic               rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_query, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_query, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/bank_cmd_sequencer.sv
// Sequences host commands onto the CAM/MAC bank pins and returns one response per command.
// Define BANK_RDBACK_EN to follow every WRITE with a read-back of the same row and flag mismatches.
module bank_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2,
  parameter int QUERY_W     = 4,
  parameter int READ_LAT    = 1,
  parameter int MODE_SW_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  bank_cmd_sequencer_if.slave      host,
  output logic                     bank_CS,
  output logic                     bank_MAC_en,
  output logic                     bank_w_en,
  output logic                     bank_read_bar,
  output logic [ADDR_W-1:0]        bank_addr,
  output logic [DATA_W-1:0]        bank_word,
  output logic [QUERY_W-1:0]       bank_query,
  input  logic [DATA_W-1:0]        bank_rdata,
  input  logic [(1<<ADDR_W)-1:0]   bank_match
);
  localparam int NUM_ROWS = 1 << ADDR_W;
  localparam int CNT_MAX  = (MODE_SW_CYC > READ_LAT) ? MODE_SW_CYC : READ_LAT;
  localparam int CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  if (DATA_W < NUM_ROWS) begin : g_bad_data_w
    $error("bank_cmd_sequencer: DATA_W must be >= NUM_ROWS to return match lines");
  end
  if (MODE_SW_CYC < 1) begin : g_bad_mode_sw
    $error("bank_cmd_sequencer: MODE_SW_CYC must be >= 1");
  end

  typedef enum logic [1:0] {OP_WRITE, OP_READ_Q, OP_READ_QB, OP_SEARCH} op_e;
  typedef enum logic [2:0] {S_IDLE, S_MODE, S_SETUP, S_ACCESS, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic [QUERY_W-1:0] query_q, query_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rb_q, rb_d;
  logic               cs_q, cs_d;
  logic               mac_en_q, mac_en_d;
  logic               w_en_q, w_en_d;
  logic               read_bar_q, read_bar_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
  logic               rsp_err_q, rsp_err_d;
  logic               capture;
  logic               need_mac;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    word_d      = word_q;
    query_d     = query_q;
    cnt_d       = cnt_q;
    rb_d        = rb_q;
    cs_d        = cs_q;
    mac_en_d    = mac_en_q;
    w_en_d      = w_en_q;
    read_bar_d  = read_bar_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    capture     = 1'b0;
    need_mac    = (op_e'(host.cmd_op) != OP_SEARCH);

    case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (host.cmd_valid && cmd_ready_q) begin
          op_d        = op_e'(host.cmd_op);
          addr_d      = host.cmd_addr;
          word_d      = host.cmd_data;
          query_d     = host.cmd_query;
          rb_d        = 1'b0;
          cmd_ready_d = 1'b0;
          cs_d        = 1'b1;
          if (need_mac != mac_en_q) begin
            state_d  = S_MODE;
            mac_en_d = need_mac;
            cnt_d    = CNT_W'(MODE_SW_CYC - 1);
          end else begin
            state_d    = S_SETUP;
            read_bar_d = (op_d == OP_READ_QB);
          end
        end
      end
      S_MODE: begin
        if (cnt_q == '0) begin
          state_d    = S_SETUP;
          read_bar_d = (op_q == OP_READ_QB);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        w_en_d  = (op_q == OP_WRITE) && !rb_q;
      end
      S_ACCESS: begin
        w_en_d = 1'b0;
        if (op_q == OP_WRITE && !rb_q) begin
`ifdef BANK_RDBACK_EN
          // Second pass over the same row as a plain READ_Q.
          rb_d    = 1'b1;
          state_d = S_SETUP;
`else
          state_d     = S_RESP;
          cs_d        = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = word_q;
          rsp_err_d   = 1'b0;
`endif
        end else if (READ_LAT == 0) begin
          capture = 1'b1;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_W'(READ_LAT - 1);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) capture = 1'b1;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_RESP: begin
        if (host.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      state_d     = S_RESP;
      cs_d        = 1'b0;
      read_bar_d  = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_data_d  = (op_q == OP_SEARCH) ? DATA_W'(bank_match) : bank_rdata;
      rsp_err_d   = rb_q && (bank_rdata != word_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= OP_WRITE;
      addr_q      <= '0;
      word_q      <= '0;
      query_q     <= '0;
      cnt_q       <= '0;
      rb_q        <= 1'b0;
      cs_q        <= 1'b0;
      mac_en_q    <= 1'b1;
      w_en_q      <= 1'b0;
      read_bar_q  <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      query_q     <= query_d;
      cnt_q       <= cnt_d;
      rb_q        <= rb_d;
      cs_q        <= cs_d;
      mac_en_q    <= mac_en_d;
      w_en_q      <= w_en_d;
      read_bar_q  <= read_bar_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign host.cmd_ready = cmd_ready_q;
  assign host.rsp_valid = rsp_valid_q;
  assign host.rsp_data  = rsp_data_q;
  assign host.rsp_err   = rsp_err_q;
  assign bank_CS        = cs_q;
  assign bank_MAC_en    = mac_en_q;
  assign bank_w_en      = w_en_q;
  assign bank_read_bar  = read_bar_q;
  assign bank_addr      = addr_q;
  assign bank_word      = word_q;
  assign bank_query     = query_q;
endmodule

// File: tb/tb_bank_cmd_sequencer.sv
// Scoreboard bench for bank_cmd_sequencer: behavioural bank + reference model, randomized commands.
// Expected responses follow BANK_RDBACK_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_bank_cmd_sequencer;
  localparam int DATA_W = 8, ADDR_W = 2, QUERY_W = 4, READ_LAT = 1, MODE_SW_CYC = 1;
  localparam int NUM_ROWS = 1 << ADDR_W;
  localparam logic [1:0] OP_WR = 2'd0, OP_RQ = 2'd1, OP_RQB = 2'd2, OP_SR = 2'd3;
`ifdef BANK_RDBACK_EN
  localparam bit RDBACK = 1'b1;
`else
  localparam bit RDBACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bank_cmd_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QUERY_W(QUERY_W)) bus ();
  logic                bank_CS, bank_MAC_en, bank_w_en, bank_read_bar;
  logic [ADDR_W-1:0]   bank_addr;
  logic [DATA_W-1:0]   bank_word, bank_rdata;
  logic [QUERY_W-1:0]  bank_query;
  logic [NUM_ROWS-1:0] bank_match;

  bank_cmd_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .QUERY_W(QUERY_W),
                       .READ_LAT(READ_LAT), .MODE_SW_CYC(MODE_SW_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .host(bus),
    .bank_CS(bank_CS), .bank_MAC_en(bank_MAC_en), .bank_w_en(bank_w_en),
    .bank_read_bar(bank_read_bar), .bank_addr(bank_addr), .bank_word(bank_word),
    .bank_query(bank_query), .bank_rdata(bank_rdata), .bank_match(bank_match)
  );

  int n_vec = 0, n_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bank model: rows may be corrupted on write to exercise read-back checking.
  logic [DATA_W-1:0] mem [NUM_ROWS];
  bit corrupt_en = 1'b0;
  function automatic logic [DATA_W-1:0] stored_val(input int a, input logic [DATA_W-1:0] d);
    return (corrupt_en && a == 1) ? (d ^ 8'h10) : d;
  endfunction
  function automatic bit row_hit(input logic [DATA_W-1:0] w, input logic [QUERY_W-1:0] q);
    return (w[DATA_W-1:QUERY_W] | w[QUERY_W-1:0]) == q;
  endfunction
  always @(posedge clk) if (bank_CS && bank_w_en) mem[bank_addr] <= stored_val(int'(bank_addr), bank_word);
  always_comb begin
    bank_rdata = bank_read_bar ? ~mem[bank_addr] : mem[bank_addr];
    for (int i = 0; i < NUM_ROWS; i++) bank_match[i] = row_hit(mem[i], bank_query);
  end

  // Reference model state and scoreboard.
  typedef struct { logic [DATA_W-1:0] data; logic err; } exp_t;
  exp_t sb_q[$];
  logic [DATA_W-1:0] ref_mem [NUM_ROWS];
  bit ref_mode = 1'b1;
  int cur_addr = 0;
  logic [DATA_W-1:0] cur_data = '0;
  int cs_cnt, wen_cnt, rb_cnt, cam_cnt;
  bit hold = 1'b0;

  always @(negedge clk) if (rst_n) begin
    if (bank_CS) cs_cnt++;
    if (bank_read_bar) rb_cnt++;
    if (bank_CS && !bank_MAC_en) cam_cnt++;
    if (bank_w_en) begin
      wen_cnt++;
      chk("wen_addr", 32'(bank_addr), cur_addr);
      chk("wen_word", 32'(bank_word), 32'(cur_data));
      chk("wen_macen", 32'(bank_MAC_en), 1);
    end
    if (bus.cmd_ready) begin
      chk("idle_cs", 32'(bank_CS), 0);
      chk("idle_rspv", 32'(bus.rsp_valid), 0);
    end
    if (bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!hold) bus.rsp_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic do_cmd(input logic [1:0] op, input int a, input logic [DATA_W-1:0] d,
                        input logic [QUERY_W-1:0] q, input bit stall);
    exp_t e;
    bit need, sw;
    int lat, n;
    logic [DATA_W-1:0] st;
    need = (op != OP_SR);
    sw = (need != ref_mode);
    ref_mode = need;
    e.err = 1'b0;
    e.data = '0;
    case (op)
      OP_WR: begin
        st = stored_val(a, d);
        ref_mem[a] = st;
        e.data = RDBACK ? st : d;
        e.err = RDBACK && (st != d);
      end
      OP_RQ:  e.data = ref_mem[a];
      OP_RQB: e.data = ~ref_mem[a];
      default: for (int i = 0; i < NUM_ROWS; i++) if (row_hit(ref_mem[i], q)) e.data[i] = 1'b1;
    endcase
    lat = 2 + ((op == OP_WR) ? 0 : READ_LAT) + (sw ? MODE_SW_CYC : 0)
            + ((RDBACK && op == OP_WR) ? 2 + READ_LAT : 0);

    @(posedge clk); #1;
    if (stall) begin hold = 1'b1; bus.rsp_ready = 1'b0; end
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = ADDR_W'(a);
    bus.cmd_data = d; bus.cmd_query = q;
    cur_addr = a; cur_data = d;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      chk("accept_timeout", 0, 1);
      bus.cmd_valid = 1'b0; hold = 1'b0;
      return;
    end
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'($urandom); bus.cmd_addr = ADDR_W'($urandom);
    bus.cmd_data = DATA_W'($urandom); bus.cmd_query = QUERY_W'($urandom);
    cs_cnt = 0; wen_cnt = 0; rb_cnt = 0; cam_cnt = 0;
    n = 0;
    while (n < 64) begin
      @(posedge clk); #1; n++;
      if (bus.rsp_valid) break;
    end
    chk("latency", n, lat);
    if (stall) begin
      bus.cmd_valid = 1'b1;
      repeat (5) begin
        @(negedge clk);
        chk("stall_rspv", 32'(bus.rsp_valid), 1);
        chk("stall_data", 32'(bus.rsp_data), 32'(e.data));
        chk("stall_ready", 32'(bus.cmd_ready), 0);
        chk("stall_cs", 32'(bank_CS), 0);
      end
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0; hold = 1'b0; bus.rsp_ready = 1'b1;
    end
    n = 0;
    while (bus.rsp_valid && n < 64) begin @(posedge clk); #1; n++; end
    chk("rsp_drop", 32'(bus.rsp_valid), 0);
    chk("ready_turn", 32'(bus.cmd_ready), 1);
    chk("cs_cycles", cs_cnt, lat);
    chk("wen_cycles", wen_cnt, (op == OP_WR) ? 1 : 0);
    chk("rdbar_cycles", rb_cnt, (op == OP_RQB) ? 2 + READ_LAT : 0);
    chk("cam_cycles", cam_cnt, (op == OP_SR) ? lat : 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cs"}, 32'(bank_CS), 0);
    chk({tag, "_wen"}, 32'(bank_w_en), 0);
    chk({tag, "_macen"}, 32'(bank_MAC_en), 1);
    chk({tag, "_ready"}, 32'(bus.cmd_ready), 0);
    chk({tag, "_rspv"}, 32'(bus.rsp_valid), 0);
    chk({tag, "_rdbar"}, 32'(bank_read_bar), 0);
  endtask

  task automatic reset_mid();
    int n;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = OP_RQ; bus.cmd_addr = '0;
    n = 0;
    @(negedge clk);
    while (!bus.cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("rst_accept", 32'(bus.cmd_ready), 1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    sb_q.delete();
    ref_mode = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_rel_before", 32'(bus.cmd_ready), 0);
    @(posedge clk); #1;
    chk("rst_rel_ready", 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] op;
    int a;
    logic [QUERY_W-1:0] q;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0;
    bus.cmd_data = '0; bus.cmd_query = '0; bus.rsp_ready = 1'b0;
    for (int i = 0; i < NUM_ROWS; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_init");
    chk("rst_init_data", 32'(bus.rsp_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_init_ready", 32'(bus.cmd_ready), 1);

    do_cmd(OP_WR, 0, 8'h27, '0, 1'b0);
    do_cmd(OP_WR, 1, 8'hA4, '0, 1'b0);
    do_cmd(OP_WR, 2, 8'h7A, '0, 1'b0);
    do_cmd(OP_WR, 3, 8'h6C, '0, 1'b0);
    do_cmd(OP_RQ, 1, '0, '0, 1'b0);
    do_cmd(OP_RQB, 3, '0, '0, 1'b0);
    do_cmd(OP_SR, 0, '0, 4'b1111, 1'b0);
    do_cmd(OP_RQ, 0, '0, '0, 1'b0);
    do_cmd(OP_RQ, 2, '0, '0, 1'b1);
    corrupt_en = 1'b1;
    do_cmd(OP_WR, 1, 8'h55, '0, 1'b0);
    corrupt_en = 1'b0;
    do_cmd(OP_RQ, 1, '0, '0, 1'b0);
    do_cmd(OP_WR, 1, 8'hA4, '0, 1'b0);

    for (int k = 0; k < 250; k++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom_range(0, NUM_ROWS - 1);
      if ($urandom_range(0, 1) == 1) begin
        logic [DATA_W-1:0] w;
        w = ref_mem[$urandom_range(0, NUM_ROWS - 1)];
        q = w[DATA_W-1:QUERY_W] | w[QUERY_W-1:0];
      end else begin
        q = QUERY_W'($urandom);
      end
      corrupt_en = ($urandom_range(0, 7) == 0);
      do_cmd(op, a, DATA_W'($urandom), q, ($urandom_range(0, 19) == 0));
    end
    corrupt_en = 1'b0;

    reset_mid();
    do_cmd(OP_SR, 0, '0, 4'hF, 1'b0);
    do_cmd(OP_RQB, 2, '0, '0, 1'b0);
    do_cmd(OP_WR, 3, 8'h3C, '0, 1'b0);
    do_cmd(OP_RQ, 3, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
